bus_reg_loader: RTL



---
 rtl/bus_reg_loader.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/bus_reg_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bus_reg_loader                                               |
// | Description : Write side of the datapath register set. Captures the shared |
// |               bus into one of sixteen general registers selected by a      |
// |               5-bit load code (0 = idle, 1..NREGS = r0..r(NREGS-1), codes  |
// |               above NREGS are illegal). Reports completion and illegal     |
// |               codes back to the control FSM.                               |
// | Ports       : clk, reset (sync, active-high), bus[WIDTH], load[5], clr_err |
// |               r0..r15[WIDTH] register contents                             |
// |               done      one-cycle pulse after a legal capture              |
// |               busy      capture cycle through done cycle (combinational)   |
// |               err       sticky illegal-code flag                           |
// |               last_dst  index of the most recently written register        |
// |               dirty     written-since-clear mask (REGBANK_DIRTY_EN only)   |
// | Option      : `define REGBANK_DIRTY_EN adds the dirty output and logic.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bus_reg_loader #(
    parameter int WIDTH = 16,
    parameter int NREGS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] bus,
    input  logic [4:0]       load,
    input  logic             clr_err,
    output logic [WIDTH-1:0] r0,
    output logic [WIDTH-1:0] r1,
    output logic [WIDTH-1:0] r2,
    output logic [WIDTH-1:0] r3,
    output logic [WIDTH-1:0] r4,
    output logic [WIDTH-1:0] r5,
    output logic [WIDTH-1:0] r6,
    output logic [WIDTH-1:0] r7,
    output logic [WIDTH-1:0] r8,
    output logic [WIDTH-1:0] r9,
    output logic [WIDTH-1:0] r10,
    output logic [WIDTH-1:0] r11,
    output logic [WIDTH-1:0] r12,
    output logic [WIDTH-1:0] r13,
    output logic [WIDTH-1:0] r14,
    output logic [WIDTH-1:0] r15,
    output logic             done,
    output logic             busy,
    output logic             err,
    output logic [3:0]       last_dst
`ifdef REGBANK_DIRTY_EN
    ,
    output logic [15:0]      dirty
`endif
);

    localparam logic [4:0] c_max_code = 5'(NREGS);

    // Two-state control: DONE is entered on every legal capture.
    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_done = 1'b1;

    logic [0:0]       r_state;
    logic             r_done;
    logic             r_err;
    logic [3:0]       r_last_dst;
    logic [WIDTH-1:0] r_regs [16];

    logic             w_legal;
    logic             w_illegal;
    logic [3:0]       w_idx;

    assign w_legal   = (load != 5'd0) && (load <= c_max_code);
    assign w_illegal = (load > c_max_code);
    // Code k selects register k-1; only meaningful while w_legal is high.
    assign w_idx     = 4'(load - 5'd1);

    // Control state, done pulse, sticky error and last destination.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_last_dst <= 4'd0;
        end else begin
            case (r_state)
                c_st_idle: r_state <= w_legal ? c_st_done : c_st_idle;
                c_st_done: r_state <= w_legal ? c_st_done : c_st_idle;
                default:   r_state <= c_st_idle;
            endcase
            r_done <= w_legal;
            if (w_legal) begin
                r_last_dst <= w_idx;
            end
            // Set has priority over clear.
            if (w_illegal) begin
                r_err <= 1'b1;
            end else if (clr_err) begin
                r_err <= 1'b0;
            end
        end
    end

    // One register per slot; at most one slot matches w_idx in any cycle.
    for (genvar gi = 0; gi < 16; gi++) begin : g_reg
        always_ff @(posedge clk) begin
            if (reset) begin
                r_regs[gi] <= '0;
            end else if (w_legal && (w_idx == 4'(gi))) begin
                r_regs[gi] <= bus;
            end
        end
    end

`ifdef REGBANK_DIRTY_EN
    logic [15:0] r_dirty;

    // Clear first, then OR in the new write so a same-cycle set wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dirty <= 16'h0000;
        end else begin
            r_dirty <= (clr_err ? 16'h0000 : r_dirty) |
                       (w_legal ? (16'h0001 << w_idx) : 16'h0000);
        end
    end

    assign dirty = r_dirty;
`endif

    assign done     = r_done;
    assign err      = r_err;
    assign last_dst = r_last_dst;
    // DONE state covers the cycle after capture; w_legal covers the capture cycle.
    assign busy     = ~reset & ((r_state == c_st_done) | w_legal);

    assign r0  = r_regs[0];
    assign r1  = r_regs[1];
    assign r2  = r_regs[2];
    assign r3  = r_regs[3];
    assign r4  = r_regs[4];
    assign r5  = r_regs[5];
    assign r6  = r_regs[6];
    assign r7  = r_regs[7];
    assign r8  = r_regs[8];
    assign r9  = r_regs[9];
    assign r10 = r_regs[10];
    assign r11 = r_regs[11];
    assign r12 = r_regs[12];
    assign r13 = r_regs[13];
    assign r14 = r_regs[14];
    assign r15 = r_regs[15];

endmodule
`default_nettype wire
